// File: rtl/serial_adder_sequencer_pkg.sv
// Shared types and sizing helpers for the serial 2-bit-slice adder sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SLICE_W = 2;

  function automatic int n_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_slice2.sv
// Combinational 2-bit ripple slice built from two gate-level full adders.
module adder_slice2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       c,
  output logic [1:0] sum,
  output logic       cout
);

  logic c1;

  assign sum[0] = a[0] ^ b[0] ^ c;
  assign c1     = (a[0] & b[0]) | (c & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign cout   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

endmodule

// File: rtl/serial_adder_sequencer.sv
// Adds two WIDTH-bit operands through one shared 2-bit slice, LSB slice first; done N cycles after accept.
// Requests are taken only while ready; start during RUN/DONE is dropped, and results hold until the next op ends.
module serial_adder_sequencer
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = n_slices(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] psum_shift;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SLICE_W-1:0] slice_sum;
  logic             slice_cout;

  adder_slice2 u_slice (
    .a    (opa_q[SLICE_W-1:0]),
    .b    (opb_q[SLICE_W-1:0]),
    .c    (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New slice enters at the top so the first (LSB) slice lands at bit 0 after N shifts.
  always_comb begin
    psum_shift = psum_q >> SLICE_W;
    psum_shift[WIDTH-1 -: SLICE_W] = slice_sum;
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> SLICE_W;
        opb_d   = opb_q >> SLICE_W;
        psum_d  = psum_shift;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          sum_d   = psum_shift;
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Scoreboard bench for serial_adder_sequencer at WIDTH=8 and WIDTH=2.
module tb_serial_adder_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ready2, busy2, done2, cout2;
  logic [1:0] sum2;

  int total = 0;
  int bad   = 0;
  int acc8 = 0, acc2 = 0, dcnt8 = 0, dcnt2 = 0;
  logic done8_prev = 1'b0, done2_prev = 1'b0;

  logic [8:0] exp8[$];
  logic [2:0] exp2[$];

  always #5 clk = ~clk;

  serial_adder_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_sequencer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected results whenever a DUT signals done.
  always @(negedge clk) begin
    if (!rst) begin
      if (done8) begin
        dcnt8++;
        total++;
        if (exp8.size() == 0) begin
          bad++;
          $display("FAIL done8_unexpected: got {cout,sum}=0x%0h with nothing pending", {cout8, sum8});
        end else begin
          logic [8:0] e;
          e = exp8.pop_front();
          if ({cout8, sum8} !== e) begin
            bad++;
            $display("FAIL result8: got 0x%0h expected 0x%0h", {cout8, sum8}, e);
          end
        end
        total++;
        if (done8_prev) begin
          bad++;
          $display("FAIL done8_width: got done high 2 cycles expected 1");
        end
      end
      if (done2) begin
        dcnt2++;
        total++;
        if (exp2.size() == 0) begin
          bad++;
          $display("FAIL done2_unexpected: got {cout,sum}=0x%0h with nothing pending", {cout2, sum2});
        end else begin
          logic [2:0] e;
          e = exp2.pop_front();
          if ({cout2, sum2} !== e) begin
            bad++;
            $display("FAIL result2: got 0x%0h expected 0x%0h", {cout2, sum2}, e);
          end
        end
        total++;
        if (done2_prev) begin
          bad++;
          $display("FAIL done2_width: got done high 2 cycles expected 1");
        end
      end
      total++;
      if (ready8 === busy8) begin
        bad++;
        $display("FAIL ready_busy8: got ready=%0b busy=%0b expected complementary", ready8, busy8);
      end
    end
    done8_prev <= done8;
    done2_prev <= done2;
  end

  // All tasks below are entered and left at a falling edge.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    int w;
    w = 0;
    while (!ready8 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready8) begin
      total++; bad++;
      $display("FAIL ready8_timeout: got ready=0 expected 1 within 20 cycles");
      return;
    end
    start8 = 1'b1; a8 = ta; b8 = tb_; cin8 = tc;
    exp8.push_back(9'(ta) + 9'(tb_) + 9'(tc));
    acc8++;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic issue2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc);
    int w;
    w = 0;
    while (!ready2 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready2) begin
      total++; bad++;
      $display("FAIL ready2_timeout: got ready=0 expected 1 within 20 cycles");
      return;
    end
    start2 = 1'b1; a2 = ta; b2 = tb_; cin2 = tc;
    exp2.push_back(3'(ta) + 3'(tb_) + 3'(tc));
    acc2++;
    @(negedge clk);
    start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done8 && lat < 20);
    if (!done8) begin
      total++; bad++;
      $display("FAIL done8_timeout: got done=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic wait_done2();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!done2 && w < 20);
    if (!done2) begin
      total++; bad++;
      $display("FAIL done2_timeout: got done=0 expected 1 within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int acc_at[$];
    logic [7:0] ha[3];
    logic [7:0] hb[3];
    int k;
    ha[0] = 8'h10; hb[0] = 8'h20;
    ha[1] = 8'hF0; hb[1] = 8'h11;
    ha[2] = 8'h7F; hb[2] = 8'h80;

    // Reset state
    #12;
    chk("rst_ready8", 32'(ready8), 1);
    chk("rst_busy8",  32'(busy8),  0);
    chk("rst_done8",  32'(done8),  0);
    chk("rst_sum8",   32'({cout8, sum8}), 0);
    chk("rst_ready2", 32'(ready2), 1);
    chk("rst_sum2",   32'({cout2, sum2}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 0xFF + 0x01: latency N=4, done single cycle
    issue8(8'hFF, 8'h01, 1'b0);
    wait_done8(lat);
    chk("latency8", 32'(lat), 4);
    @(negedge clk);
    chk("done8_drop", 32'(done8), 0);
    chk("ready8_after", 32'(ready8), 1);

    issue8(8'hA5, 8'h5A, 1'b1);
    wait_done8(lat);
    chk("sum_a5_5a", 32'({cout8, sum8}), 32'h100);

    // Previous result holds until the final RUN edge
    issue8(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    chk("hold_mid", 32'({cout8, sum8}), 32'h100);
    @(negedge clk);
    chk("hold_late", 32'({cout8, sum8}), 32'h100);
    wait_done8(lat);
    chk("sum_12_34", 32'({cout8, sum8}), 32'h046);
    @(negedge clk);

    // start held high: accepts every N+2 cycles, junk operands while busy
    k = 0;
    start8 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (ready8) begin
        acc_at.push_back(i);
        a8 = ha[k % 3]; b8 = hb[k % 3]; cin8 = 1'b0;
        exp8.push_back(9'(ha[k % 3]) + 9'(hb[k % 3]));
        acc8++;
        k++;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("held_accepts", 32'(acc_at.size()), 3);
    if (acc_at.size() == 3) begin
      chk("held_gap1", 32'(acc_at[1] - acc_at[0]), 6);
      chk("held_gap2", 32'(acc_at[2] - acc_at[1]), 6);
    end
    repeat (2) @(negedge clk);

    // Reset at the 2nd RUN edge discards the operation
    issue8(8'h33, 8'h44, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(ready8), 1);
    chk("mid_rst_busy",  32'(busy8),  0);
    chk("mid_rst_sum",   32'({cout8, sum8}), 0);
    exp8.delete();
    acc8--;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue8(8'h80, 8'h80, 1'b1);
    wait_done8(lat);
    chk("post_rst_sum", 32'({cout8, sum8}), 32'h101);

    // WIDTH=2 exhaustive
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          issue2(2'(x), 2'(y), 1'(c));
          wait_done2();
        end

    // WIDTH=8 random operands
    for (int i = 0; i < 1000; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8(lat);
    end

    repeat (10) @(negedge clk);
    chk("pending8", 32'(exp8.size()), 0);
    chk("pending2", 32'(exp2.size()), 0);
    chk("done_count8", 32'(dcnt8), 32'(acc8));
    chk("done_count2", 32'(dcnt2), 32'(acc2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
